// File: rtl/dmem_responder_if.sv
// Data-memory port bundle between the pipeline (master) and the memory responder (slave).
interface dmem_responder_if;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one outstanding request, single-cycle resp,
// reads sample the array before the request's own write commits at the end of RESP.

module dmem_lane #(
  parameter int VEC_W = 8
) (
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [VEC_W-1:0] mem_byte,
  input  logic [VEC_W-1:0] wdata_byte,
  output logic [VEC_W-1:0] rd_byte,
  output logic [VEC_W-1:0] wr_byte
);
  assign rd_byte = rd_en ? mem_byte : '0;
  assign wr_byte = wr_en ? wdata_byte : mem_byte;
endmodule

module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output logic              busy,
  output logic [15:0]       req_count
);
  localparam int AW        = $clog2(DEPTH_WORDS);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  generate
    if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0 || DEPTH_WORDS < 4 || DEPTH_WORDS > 65536 ||
        LATENCY < 1 || LATENCY > 15) begin : g_bad_param
      $error("dmem_responder: illegal DEPTH_WORDS or LATENCY");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic [AW-1:0]          cap_idx;
  logic [NUM_LANES-1:0]   cap_rmask;
  logic [NUM_LANES-1:0]   cap_wmask;
  logic [31:0]            cap_wdata;
  logic                   resp_q;
  logic [31:0]            rdata_q;
  logic [15:0]            req_count_q;

  logic [31:0]            mem [DEPTH_WORDS];

  logic [AW-1:0]          in_idx;
  logic                   req_in;
  logic [AW-1:0]          rd_idx;
  logic [NUM_LANES-1:0]   rd_mask;
  logic [31:0]            rd_word;
  logic [NUM_LANES-1:0][VEC_W-1:0] rd_bytes;
  logic [NUM_LANES-1:0][VEC_W-1:0] wr_bytes;
  logic                   unused_addr;

  assign in_idx      = bus.dmem_addr[AW+1:2];
  assign unused_addr = ^{bus.dmem_addr[31:AW+2], bus.dmem_addr[1:0]};
  assign req_in      = (|bus.dmem_rmask) | (|bus.dmem_wmask);

  // With LATENCY=1 the read happens on the accepting edge, before the capture registers load.
  assign rd_idx  = (state == IDLE) ? in_idx : cap_idx;
  assign rd_mask = (state == IDLE) ? bus.dmem_rmask : cap_rmask;
  assign rd_word = mem[rd_idx];

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      dmem_lane #(.VEC_W(VEC_W)) u_lane (
        .rd_en      (rd_mask[g]),
        .wr_en      (cap_wmask[g]),
        .mem_byte   (rd_word[g*VEC_W +: VEC_W]),
        .wdata_byte (cap_wdata[g*VEC_W +: VEC_W]),
        .rd_byte    (rd_bytes[g]),
        .wr_byte    (wr_bytes[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cap_idx     <= '0;
      cap_rmask   <= '0;
      cap_wmask   <= '0;
      cap_wdata   <= '0;
      resp_q      <= 1'b0;
      rdata_q     <= '0;
      busy        <= 1'b0;
      req_count_q <= '0;
    end else begin
      resp_q  <= 1'b0;
      rdata_q <= '0;
      case (state)
        IDLE: begin
          if (req_in) begin
            cap_idx   <= in_idx;
            cap_rmask <= bus.dmem_rmask;
            cap_wmask <= bus.dmem_wmask;
            cap_wdata <= bus.dmem_wdata;
            busy      <= 1'b1;
            if (LATENCY == 1) begin
              state   <= RESP;
              resp_q  <= 1'b1;
              rdata_q <= rd_bytes;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state   <= RESP;
            cnt     <= '0;
            resp_q  <= 1'b1;
            rdata_q <= rd_bytes;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state       <= IDLE;
          busy        <= 1'b0;
          req_count_q <= req_count_q + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset forces state to IDLE asynchronously, so an abandoned RESP never commits.
  always_ff @(posedge clk) begin
    if (state == RESP && (|cap_wmask))
      mem[cap_idx] <= wr_bytes;
  end

  assign bus.dmem_resp  = resp_q;
  assign bus.dmem_rdata = rdata_q;
  assign req_count      = req_count_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=3 instance for data paths, LATENCY=1 for hold/wrap.
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic        busy_a, busy_b;
  logic [15:0] cnt_a, cnt_b;
  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_a (
    .clk(clk), .rst(rst_a), .bus(bus_a), .busy(busy_a), .req_count(cnt_a));
  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_b (
    .clk(clk), .rst(rst_b), .bus(bus_b), .busy(busy_b), .req_count(cnt_b));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rm;
    logic [3:0]  wm;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[11];

  task automatic drive_a(input logic [31:0] addr, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] wd);
    bus_a.dmem_addr  = addr;
    bus_a.dmem_rmask = rm;
    bus_a.dmem_wmask = wm;
    bus_a.dmem_wdata = wd;
  endtask

  // Waits for resp starting in cycle k (k = cycles since acceptance); returns k at resp.
  task automatic wait_resp_a(input int k0, output int k);
    k = k0;
    while (bus_a.dmem_resp !== 1'b1 && k < 20) begin
      check("busy_while_wait", busy_a, 1);
      check("rdata_zero_no_resp", bus_a.dmem_rdata, 0);
      @(negedge clk);
      k++;
    end
  endtask

  task automatic do_req_a(input vec_t v, input string name);
    int k;
    @(negedge clk);
    drive_a(v.addr, v.rm, v.wm, v.wd);
    @(negedge clk);
    // request vanishes after acceptance; garbage must not leak in
    drive_a(32'hFFFF_FFFC, 4'h0, 4'h0, 32'hA5A5_A5A5);
    wait_resp_a(1, k);
    check({name, "_lat"}, k, 3);
    check({name, "_rdata"}, bus_a.dmem_rdata, v.exp);
    @(negedge clk);
    check({name, "_busy_after"}, busy_a, 0);
    check({name, "_resp_after"}, bus_a.dmem_resp, 0);
  endtask

  initial begin
    int k;
    int pulses;
    tbl[0]  = '{32'h0000_0080, 4'h0, 4'hF, 32'h1122_3344, 32'h0000_0000};
    tbl[1]  = '{32'h0000_0080, 4'h0, 4'h2, 32'h0000_AA00, 32'h0000_0000};
    tbl[2]  = '{32'h0000_0080, 4'h6, 4'h0, 32'h0000_0000, 32'h0022_AA00};
    tbl[3]  = '{32'h0000_0010, 4'h0, 4'hF, 32'h0000_0001, 32'h0000_0000};
    tbl[4]  = '{32'h0000_0010, 4'hF, 4'hF, 32'h0000_0002, 32'h0000_0001};
    tbl[5]  = '{32'h0000_0010, 4'hF, 4'h0, 32'h0000_0000, 32'h0000_0002};
    tbl[6]  = '{32'h0000_1004, 4'h0, 4'hF, 32'h1234_5678, 32'h0000_0000};
    tbl[7]  = '{32'h0000_0004, 4'hF, 4'h0, 32'h0000_0000, 32'h1234_5678};
    tbl[8]  = '{32'h0000_0040, 4'h1, 4'h0, 32'h0000_0000, 32'h0000_00EF};
    tbl[9]  = '{32'h0000_1043, 4'h8, 4'h0, 32'h0000_0000, 32'hDE00_0000};
    tbl[10] = '{32'h0000_0020, 4'h0, 4'hF, 32'h0000_0000, 32'h0000_0000};

    rst_a = 1'b0;
    rst_b = 1'b0;
    drive_a(32'h0, 4'h0, 4'h0, 32'h0);
    bus_b.dmem_addr  = 32'h0;
    bus_b.dmem_rmask = 4'h0;
    bus_b.dmem_wmask = 4'h0;
    bus_b.dmem_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_resp_a",  bus_a.dmem_resp, 0);
    check("rst_rdata_a", bus_a.dmem_rdata, 0);
    check("rst_busy_a",  busy_a, 0);
    check("rst_cnt_a",   cnt_a, 0);
    check("rst_resp_b",  bus_b.dmem_resp, 0);
    check("rst_busy_b",  busy_b, 0);
    check("rst_cnt_b",   cnt_b, 0);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // store then back-to-back load; cycle numbers relative to the store's IDLE cycle
    @(negedge clk);
    drive_a(32'h40, 4'h0, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    drive_a(32'h0, 4'h0, 4'h0, 32'h0);
    wait_resp_a(1, k);
    check("st_resp_cycle", k, 3);
    drive_a(32'h40, 4'hF, 4'h0, 32'h0);
    @(negedge clk);
    check("ld_idle_t4_busy", busy_a, 0);
    @(negedge clk);
    drive_a(32'h0, 4'h0, 4'h0, 32'h0);
    check("ld_accepted_t4", busy_a, 1);
    wait_resp_a(5, k);
    check("ld_resp_cycle", k, 7);
    check("ld_rdata", bus_a.dmem_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("cnt_after_two", cnt_a, 2);

    for (int i = 0; i < 11; i++) do_req_a(tbl[i], $sformatf("vec%0d", i));
    check("cnt_after_table", cnt_a, 13);

    // zero masks in IDLE are ignored
    drive_a(32'h40, 4'h0, 4'h0, 32'hFFFF_FFFF);
    repeat (3) begin
      @(negedge clk);
      check("zero_mask_busy", busy_a, 0);
    end
    check("zero_mask_cnt", cnt_a, 13);

    // reset during RESP of a store: write dropped, count cleared
    drive_a(32'h20, 4'h0, 4'hF, 32'h0000_0055);
    @(negedge clk);
    drive_a(32'h0, 4'h0, 4'h0, 32'h0);
    wait_resp_a(1, k);
    check("rst_mid_resp_seen", k, 3);
    rst_a = 1'b0;
    #1;
    check("rst_mid_resp",  bus_a.dmem_resp, 0);
    check("rst_mid_rdata", bus_a.dmem_rdata, 0);
    check("rst_mid_busy",  busy_a, 0);
    check("rst_mid_cnt",   cnt_a, 0);
    @(negedge clk);
    rst_a = 1'b1;
    do_req_a('{32'h20, 4'hF, 4'h0, 32'h0, 32'h0000_0000}, "rst_ld");
    check("rst_ld_cnt", cnt_a, 1);

    // LATENCY=1: request held two cycles gives one response
    @(negedge clk);
    bus_b.dmem_addr  = 32'h0;
    bus_b.dmem_wmask = 4'hF;
    bus_b.dmem_wdata = 32'h0000_0077;
    @(negedge clk);
    check("hold_resp_t1", bus_b.dmem_resp, 1);
    pulses = 1;
    @(negedge clk);
    bus_b.dmem_wmask = 4'h0;
    for (int i = 0; i < 5; i++) begin
      if (bus_b.dmem_resp === 1'b1) pulses++;
      @(negedge clk);
    end
    check("hold_pulses", pulses, 1);
    check("hold_cnt", cnt_b, 1);
    bus_b.dmem_rmask = 4'hF;
    @(negedge clk);
    bus_b.dmem_rmask = 4'h0;
    check("b_ld_resp",  bus_b.dmem_resp, 1);
    check("b_ld_rdata", bus_b.dmem_rdata, 32'h0000_0077);
    @(negedge clk);
    check("b_cnt", cnt_b, 2);

    // counter wrap
    force u_b.req_count_q = 16'hFFFF;
    @(negedge clk);
    release u_b.req_count_q;
    @(negedge clk);
    check("wrap_pre", cnt_b, 16'hFFFF);
    bus_b.dmem_rmask = 4'h1;
    @(negedge clk);
    bus_b.dmem_rmask = 4'h0;
    @(negedge clk);
    check("wrap_cnt", cnt_b, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the pipeline's data-memory port: the other end of the `dmem_resp` handshake that the pipeline's freeze logic waits on. It accepts one load/store request at a time, holds it for a fixed, parameterised latency, then returns a single-cycle `dmem_resp` with read data and commits write lanes to an internal word array. It serves as the synthesizable dmem model for pipeline integration and stall-path testing.

## Interface

- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; must be a power of two, 4 to 65536.
- `LATENCY`, 3: cycles from request acceptance to `dmem_resp`; must be 1 to 15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `dmem_addr`  in  32  byte address; bits [1:0] ignored; word index = `addr[log2(DEPTH_WORDS)+1:2]`; upper bits ignored (aliasing).
- `dmem_rmask`  in  4  byte-lane read enables; nonzero marks a load.
- `dmem_wmask`  in  4  byte-lane write enables; nonzero marks a store.
- `dmem_wdata`  in  32  store data, lane-aligned.
- `dmem_rdata`  out  32  load data; meaningful only while `dmem_resp`=1.
- `dmem_resp`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while a request is outstanding (WAIT or RESP).
- `req_count`  out  16  number of completed requests; wraps 0xFFFF to 0x0000.

## Operation

- FSM states:
  - IDLE: `busy`=0. If `rmask|wmask` ≠ 0 at a rising edge, capture addr, rmask, wmask and wdata, load the latency counter with `LATENCY-1`, and go to WAIT. If `LATENCY`=1, go directly to RESP.
  - WAIT: decrement the counter each cycle; go to RESP when it reaches 1. Inputs are ignored; the captured copy is used.
  - RESP: `dmem_resp`=1 for exactly one cycle. At the end of the cycle:
    - write every lane i with `wmask[i]`=1 using `wdata[8i+7:8i]`;
    - increment `req_count`;
    - go to IDLE.
- No request is accepted in RESP. The earliest next acceptance is the first IDLE cycle.
- Read data:
  - Lane i of `dmem_rdata` = array byte if `rmask[i]`=1, else 0x00.
  - Data is sampled from the array as it stood before this request's own write.
  - `dmem_rdata`=0 whenever `dmem_resp`=0.
- Combined request (`rmask` and `wmask` both nonzero): read returns old data and the write commits at end of RESP. One response covers both.
- Array contents are not cleared by reset; they are undefined until written.

## Timing

- Reset values: `dmem_resp`=0, `dmem_rdata`=0, `busy`=0, `req_count`=0, FSM=IDLE, counter=0.
- Request present in IDLE cycle T:
  - `busy`=1 in cycles T+1 through T+LATENCY;
  - `dmem_resp`=1 only in cycle T+LATENCY;
  - `busy`=0 in cycle T+LATENCY+1.
- A requester that holds the request through its freeze sees it accepted once only.
- If the requester changes its mask in cycle T+LATENCY+1, that new request is accepted in T+LATENCY+1. The back-to-back throughput is one request per LATENCY+1 cycles.
- Requests with zero masks in IDLE are ignored: no state change and no count.
- A request that disappears after acceptance still completes with the captured values.
- Reset asserted mid-operation:
  - WAIT/RESP is abandoned immediately and all outputs take their reset values asynchronously.
  - A write pending in RESP is not committed if reset is asserted before that edge.
  - After release, the FSM is in IDLE.
- Address aliasing: with DEPTH_WORDS=1024, addresses 0x0000_0000 and 0x0000_1000 map to the same word.

## Test plan

- **Store then load, LATENCY=3.**
  - Stimulus: store addr 0x40, wmask 0xF, wdata 0xDEADBEEF at T=0; then load addr 0x40, rmask 0xF.
  - Required: store resp at T=3; load accepted at T=4; load resp at T=7 with rdata 0xDEADBEEF; `req_count`=2.
- **Byte lanes.**
  - Stimulus: word 0x80 = 0x11223344; store wmask 0x2, wdata 0x0000AA00; then load rmask 0x6.
  - Required: rdata 0x0022AA00.
- **Combined read/write.**
  - Stimulus: word 0x10 = 0x00000001; one request with rmask 0xF, wmask 0xF, wdata 0x00000002.
  - Required: rdata 0x00000001; a following load returns 0x00000002.
- **Held request and LATENCY=1.**
  - Stimulus: LATENCY=1; request held high for 2 cycles, then masks dropped.
  - Required: exactly one `dmem_resp` pulse, in the cycle after acceptance; `req_count`=1.
- **Reset mid-operation.**
  - Stimulus: assert `rst`=0 during RESP of a store of 0x55 to 0x20 (word previously 0x0); release; load 0x20.
  - Required: outputs zero immediately on assertion; load returns 0x00000000; `req_count`=1 (the load only).
- **Aliasing and wrap.**
  - Stimulus: store 0x12345678 to 0x1004; load 0x0004.
  - Required: rdata 0x12345678.
  - Stimulus: preset `req_count` to 0xFFFF via 65535 requests; one more request.
  - Required: `req_count`=0x0000.
